// File: rtl/icache_port_arbiter_if.sv
// Bundle between the fetch requesters, the arbiter and the shared instruction-cache port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface icache_port_arbiter_if #(
   parameter int NumReq    = 4,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic [NumReq-1:0]                req_valid_i;
   logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
   logic [NumReq-1:0]                req_ready_o;
   logic [NumReq-1:0][DataWidth-1:0] req_data_o;
   logic [NumReq-1:0]                req_error_o;
   logic [NumReq-1:0]                flush_valid_i;
   logic [NumReq-1:0]                flush_ready_o;
   logic                             inst_valid_o;
   logic [AddrWidth-1:0]             inst_addr_o;
   logic                             inst_ready_i;
   logic [DataWidth-1:0]             inst_data_i;
   logic                             inst_error_i;
   logic                             cache_flush_valid_o;
   logic                             cache_flush_ready_i;
   logic                             busy_o;

   modport slave (
      input  req_valid_i, req_addr_i, flush_valid_i,
      input  inst_ready_i, inst_data_i, inst_error_i, cache_flush_ready_i,
      output req_ready_o, req_data_o, req_error_o, flush_ready_o,
      output inst_valid_o, inst_addr_o, cache_flush_valid_o, busy_o
   );

   modport master (
      output req_valid_i, req_addr_i, flush_valid_i,
      output inst_ready_i, inst_data_i, inst_error_i, cache_flush_ready_i,
      input  req_ready_o, req_data_o, req_error_o, flush_ready_o,
      input  inst_valid_o, inst_addr_o, cache_flush_valid_o, busy_o
   );
endinterface

// File: rtl/icache_port_arbiter.sv
// Round-robin arbiter sharing one instruction-cache fetch port among NumReq requesters,
// with a stalled fetch held locked to its owner and flush requests serialised to the cache.
module icache_port_arbiter #(
   parameter int NumReq    = 4,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   icache_port_arbiter_if.slave bus
);
   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic [1:0] {IDLE, LOCK, FLUSH} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
   logic [NumReq-1:0] flush_mask_q, flush_mask_d;
   logic [IdxW-1:0]   winner;
   logic              any_req;
   logic              any_flush;

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
      if (int'(idx) == NumReq - 1) return '0;
      return idx + IdxW'(1);
   endfunction

   assign any_flush       = |bus.flush_valid_i;
   assign bus.req_data_o  = {NumReq{bus.inst_data_i}};
   assign bus.req_error_o = {NumReq{bus.inst_error_i}};

   // First valid requester at or after rr_ptr_q, wrapping.
   always_comb begin : pick
      int              idx;
      logic [IdxW-1:0] cand;
      idx     = 0;
      cand    = '0;
      winner  = rr_ptr_q;
      any_req = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NumReq) idx = idx - NumReq;
         cand = IdxW'(idx);
         if (!any_req && bus.req_valid_i[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         lock_idx_q   <= '0;
         flush_mask_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         lock_idx_q   <= lock_idx_d;
         flush_mask_q <= flush_mask_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      lock_idx_d   = lock_idx_q;
      flush_mask_d = flush_mask_q;
      unique case (state_q)
         IDLE: begin
            if (any_flush) begin
               flush_mask_d = bus.flush_valid_i;
               state_d      = FLUSH;
            end else if (any_req) begin
               if (bus.inst_ready_i) begin
                  rr_ptr_d = next_idx(winner);
               end else begin
                  lock_idx_d = winner;
                  state_d    = LOCK;
               end
            end
         end
         LOCK: begin
            if (bus.inst_ready_i) begin
               rr_ptr_d = next_idx(lock_idx_q);
               state_d  = IDLE;
            end
         end
         FLUSH: begin
            if (bus.cache_flush_ready_i) begin
               flush_mask_d = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, since IDLE alone would still grant.
   always_comb begin
      bus.req_ready_o         = '0;
      bus.flush_ready_o       = '0;
      bus.inst_valid_o        = 1'b0;
      bus.inst_addr_o         = '0;
      bus.cache_flush_valid_o = 1'b0;
      bus.busy_o              = 1'b0;
      if (!rst_i) begin
         bus.busy_o = (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (!any_flush && any_req) begin
                  bus.inst_valid_o        = 1'b1;
                  bus.inst_addr_o         = bus.req_addr_i[winner];
                  bus.req_ready_o[winner] = bus.inst_ready_i;
               end
            end
            LOCK: begin
               bus.inst_valid_o            = 1'b1;
               bus.inst_addr_o             = bus.req_addr_i[lock_idx_q];
               bus.req_ready_o[lock_idx_q] = bus.inst_ready_i;
            end
            FLUSH: begin
               bus.cache_flush_valid_o = 1'b1;
               if (bus.cache_flush_ready_i) bus.flush_ready_o = flush_mask_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_icache_port_arbiter.sv
// Bench for icache_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration and flush rules.
module tb_icache_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk_i = 1'b0;
   logic rst_i;

   icache_port_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) bus();

   icache_port_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model: owner of a stalled fetch, pending flush set, next priority start.
   int           m_owner;
   int           m_start;
   bit           m_flushing;
   logic [N-1:0] m_set;

   task automatic drive_idle();
      bus.req_valid_i         = '0;
      bus.req_addr_i          = '0;
      bus.flush_valid_i       = '0;
      bus.inst_ready_i        = 1'b0;
      bus.inst_data_i         = '0;
      bus.inst_error_i        = 1'b0;
      bus.cache_flush_ready_i = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_i = 1'b1;
      next_cycle();
      next_cycle();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_i = 1'b1;
      bus.req_valid_i         = 4'b1111;
      bus.flush_valid_i       = 4'b1111;
      bus.inst_ready_i        = 1'b1;
      bus.cache_flush_ready_i = 1'b1;
      bus.inst_data_i         = 32'hDEAD_BEEF;
      bus.inst_error_i        = 1'b1;
      for (int i = 0; i < N; i++) bus.req_addr_i[i] = 32'h1000 + i;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0000) begin
         errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready_o);
      end
      checks++;
      if (bus.inst_valid_o !== 1'b0 || bus.cache_flush_valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valids got inst=%b cflush=%b want 0 0", bus.inst_valid_o, bus.cache_flush_valid_o);
      end
      checks++;
      if (bus.flush_ready_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_flush_busy got fr=%b busy=%b want 0000 0", bus.flush_ready_o, bus.busy_o);
      end
      checks++;
      if (bus.inst_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_inst_addr got %h want 00000000", bus.inst_addr_o);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.req_data_o[i] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL reset_req_data lane %0d got %h want deadbeef", i, bus.req_data_o[i]);
         end
      end
      checks++;
      if (bus.req_error_o !== 4'b1111) begin
         errors++; $display("FAIL reset_req_error got %b want 1111", bus.req_error_o);
      end
      next_cycle();
      drive_idle();
      rst_i = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      bus.req_valid_i  = 4'b1111;
      bus.inst_ready_i = 1'b1;
      for (int i = 0; i < N; i++) bus.req_addr_i[i] = 32'h40 + 32'(i) * 32'h10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         checks++;
         if (bus.req_ready_o !== exp_seq[k]) begin
            errors++; $display("FAIL rr_ready step %0d got %b want %b", k, bus.req_ready_o, exp_seq[k]);
         end
         checks++;
         if (bus.inst_addr_o !== 32'h40 + 32'(k % N) * 32'h10 || bus.inst_valid_o !== 1'b1) begin
            errors++; $display("FAIL rr_addr step %0d got %h/%b want %h/1", k, bus.inst_addr_o, bus.inst_valid_o,
                               32'h40 + 32'(k % N) * 32'h10);
         end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_lock();
      do_reset();
      bus.req_valid_i   = 4'b0100;
      bus.req_addr_i[2] = 32'h100;
      bus.req_addr_i[0] = 32'h40;
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) bus.req_valid_i[0] = 1'b1;
         if (c == 4) bus.inst_ready_i = 1'b1;
         @(negedge clk_i);
         checks++;
         if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h100) begin
            errors++; $display("FAIL lock_addr cycle %0d got %b/%h want 1/00000100", c, bus.inst_valid_o, bus.inst_addr_o);
         end
         checks++;
         if (bus.req_ready_o !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL lock_ready cycle %0d got %b want %b", c, bus.req_ready_o, (c == 4) ? 4'b0100 : 4'b0000);
         end
         checks++;
         if (bus.busy_o !== (c != 1)) begin
            errors++; $display("FAIL lock_busy cycle %0d got %b want %b", c, bus.busy_o, c != 1);
         end
         next_cycle();
      end
      bus.req_valid_i = 4'b0001;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001 || bus.inst_addr_o !== 32'h40) begin
         errors++; $display("FAIL lock_next got %b/%h want 0001/00000040", bus.req_ready_o, bus.inst_addr_o);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_idle_no_req();
      do_reset();
      bus.req_valid_i   = 4'b0001;
      bus.req_addr_i[0] = 32'hA0;
      bus.req_addr_i[1] = 32'hA4;
      bus.inst_ready_i  = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001) begin
         errors++; $display("FAIL idle_first got %b want 0001", bus.req_ready_o);
      end
      next_cycle();
      bus.req_valid_i = 4'b0000;
      @(negedge clk_i);
      checks++;
      if (bus.inst_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL idle_quiet got iv=%b rr=%b busy=%b want 0 0000 0", bus.inst_valid_o, bus.req_ready_o, bus.busy_o);
      end
      next_cycle();
      bus.req_valid_i = 4'b0011;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0010 || bus.inst_addr_o !== 32'hA4) begin
         errors++; $display("FAIL idle_ptr_kept got %b/%h want 0010/000000a4", bus.req_ready_o, bus.inst_addr_o);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_flush();
      do_reset();
      bus.flush_valid_i = 4'b0011;
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) bus.cache_flush_ready_i = 1'b1;
         if (c == 4) begin bus.cache_flush_ready_i = 1'b0; bus.flush_valid_i = 4'b0000; end
         @(negedge clk_i);
         checks++;
         if (bus.cache_flush_valid_o !== (c == 2 || c == 3) || bus.inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_valid cycle %0d got cf=%b iv=%b want %b 0", c, bus.cache_flush_valid_o,
                               bus.inst_valid_o, c == 2 || c == 3);
         end
         checks++;
         if (bus.flush_ready_o !== ((c == 3) ? 4'b0011 : 4'b0000)) begin
            errors++; $display("FAIL flush_ready cycle %0d got %b want %b", c, bus.flush_ready_o, (c == 3) ? 4'b0011 : 4'b0000);
         end
         checks++;
         if (bus.busy_o !== (c == 2 || c == 3)) begin
            errors++; $display("FAIL flush_busy cycle %0d got %b want %b", c, bus.busy_o, c == 2 || c == 3);
         end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_flush_during_lock();
      do_reset();
      bus.req_valid_i   = 4'b0010;
      bus.req_addr_i[1] = 32'h200;
      next_cycle();
      bus.flush_valid_i = 4'b1000;
      @(negedge clk_i);
      checks++;
      if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h200 || bus.cache_flush_valid_o !== 1'b0) begin
         errors++; $display("FAIL fl_lock_hold got iv=%b a=%h cf=%b want 1 00000200 0", bus.inst_valid_o, bus.inst_addr_o,
                            bus.cache_flush_valid_o);
      end
      next_cycle();
      bus.inst_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0010 || bus.flush_ready_o !== 4'b0000) begin
         errors++; $display("FAIL fl_lock_done got rr=%b fr=%b want 0010 0000", bus.req_ready_o, bus.flush_ready_o);
      end
      next_cycle();
      bus.req_valid_i  = 4'b0000;
      bus.inst_ready_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (bus.inst_valid_o !== 1'b0 || bus.cache_flush_valid_o !== 1'b0) begin
         errors++; $display("FAIL fl_lock_latch got iv=%b cf=%b want 0 0", bus.inst_valid_o, bus.cache_flush_valid_o);
      end
      next_cycle();
      bus.cache_flush_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.cache_flush_valid_o !== 1'b1 || bus.flush_ready_o !== 4'b1000) begin
         errors++; $display("FAIL fl_lock_ack got cf=%b fr=%b want 1 1000", bus.cache_flush_valid_o, bus.flush_ready_o);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_flush_mask();
      do_reset();
      bus.flush_valid_i = 4'b0001;
      next_cycle();
      bus.flush_valid_i = 4'b0011;
      @(negedge clk_i);
      checks++;
      if (bus.flush_ready_o !== 4'b0000 || bus.cache_flush_valid_o !== 1'b1) begin
         errors++; $display("FAIL mask_wait got fr=%b cf=%b want 0000 1", bus.flush_ready_o, bus.cache_flush_valid_o);
      end
      next_cycle();
      bus.cache_flush_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.flush_ready_o !== 4'b0001) begin
         errors++; $display("FAIL mask_first got %b want 0001", bus.flush_ready_o);
      end
      next_cycle();
      bus.flush_valid_i       = 4'b0010;
      bus.cache_flush_ready_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (bus.cache_flush_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL mask_idle got cf=%b busy=%b want 0 0", bus.cache_flush_valid_o, bus.busy_o);
      end
      next_cycle();
      bus.cache_flush_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.flush_ready_o !== 4'b0010) begin
         errors++; $display("FAIL mask_second got %b want 0010", bus.flush_ready_o);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      bus.flush_valid_i = 4'b0100;
      next_cycle();
      @(negedge clk_i);
      checks++;
      if (bus.cache_flush_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin
         errors++; $display("FAIL rstfl_pre got cf=%b busy=%b want 1 1", bus.cache_flush_valid_o, bus.busy_o);
      end
      #1;
      bus.cache_flush_ready_i = 1'b1;
      rst_i = 1'b1;
      #1;
      checks++;
      if (bus.cache_flush_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.flush_ready_o !== 4'b0000) begin
         errors++; $display("FAIL rstfl_drop got cf=%b busy=%b fr=%b want 0 0 0000", bus.cache_flush_valid_o, bus.busy_o,
                            bus.flush_ready_o);
      end
      next_cycle();
      drive_idle();
      rst_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         checks++;
         if (bus.flush_ready_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL rstfl_after cycle %0d got fr=%b busy=%b want 0000 0", c, bus.flush_ready_o, bus.busy_o);
         end
         next_cycle();
      end
   endtask

   task automatic test_random();
      logic [N-1:0]         rv, fv, got_r, got_f;
      logic [N-1:0][AW-1:0] ra;
      logic [N-1:0]         e_rr, e_fr;
      logic [AW-1:0]        e_ia;
      logic                 e_iv, e_cfv, e_busy, ir, cfr;
      int                   n_owner, n_start, w;
      bit                   n_flushing;
      logic [N-1:0]         n_set;
      do_reset();
      m_owner = -1; m_start = 0; m_flushing = 0; m_set = '0;
      rv = '0; fv = '0; ra = '0; got_r = '0; got_f = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (rv[i] && got_r[i]) rv[i] = 1'b0;
            if (fv[i] && got_f[i]) fv[i] = 1'b0;
            if (!rv[i] && $urandom_range(3) == 0) begin rv[i] = 1'b1; ra[i] = $urandom; end
            if (!fv[i] && $urandom_range(60) == 0) fv[i] = 1'b1;
         end
         ir  = ($urandom_range(2) != 0);
         cfr = ($urandom_range(2) == 0);
         bus.req_valid_i         = rv;
         bus.req_addr_i          = ra;
         bus.flush_valid_i       = fv;
         bus.inst_ready_i        = ir;
         bus.cache_flush_ready_i = cfr;
         bus.inst_data_i         = $urandom;
         bus.inst_error_i        = 1'($urandom_range(1));
         @(negedge clk_i);
         e_rr = '0; e_fr = '0; e_iv = 1'b0; e_ia = '0; e_cfv = 1'b0; e_busy = 1'b0;
         n_owner = m_owner; n_start = m_start; n_flushing = m_flushing; n_set = m_set;
         if (m_flushing) begin
            e_cfv = 1'b1; e_busy = 1'b1;
            if (cfr) begin e_fr = m_set; n_flushing = 0; n_set = '0; end
         end else if (m_owner >= 0) begin
            e_iv = 1'b1; e_ia = ra[m_owner]; e_busy = 1'b1;
            if (ir) begin e_rr[m_owner] = 1'b1; n_owner = -1; n_start = (m_owner + 1) % N; end
         end else if (fv != '0) begin
            n_flushing = 1; n_set = fv;
         end else begin
            w = -1;
            for (int k = 0; k < N; k++) if (w < 0 && rv[(m_start + k) % N]) w = (m_start + k) % N;
            if (w >= 0) begin
               e_iv = 1'b1; e_ia = ra[w];
               if (ir) begin e_rr[w] = 1'b1; n_start = (w + 1) % N; end
               else n_owner = w;
            end
         end
         checks++;
         if (bus.req_ready_o !== e_rr) begin
            errors++; $display("FAIL rand_req_ready cyc %0d got %b want %b", cyc, bus.req_ready_o, e_rr);
         end
         checks++;
         if (bus.inst_valid_o !== e_iv || (e_iv && bus.inst_addr_o !== e_ia)) begin
            errors++; $display("FAIL rand_inst cyc %0d got %b/%h want %b/%h", cyc, bus.inst_valid_o, bus.inst_addr_o, e_iv, e_ia);
         end
         checks++;
         if (bus.cache_flush_valid_o !== e_cfv || bus.flush_ready_o !== e_fr) begin
            errors++; $display("FAIL rand_flush cyc %0d got %b/%b want %b/%b", cyc, bus.cache_flush_valid_o, bus.flush_ready_o,
                               e_cfv, e_fr);
         end
         checks++;
         if (bus.busy_o !== e_busy) begin
            errors++; $display("FAIL rand_busy cyc %0d got %b want %b", cyc, bus.busy_o, e_busy);
         end
         checks++;
         if (bus.req_data_o[cyc % N] !== bus.inst_data_i || bus.req_error_o !== {N{bus.inst_error_i}}) begin
            errors++; $display("FAIL rand_data cyc %0d got %h/%b want %h/%b", cyc, bus.req_data_o[cyc % N], bus.req_error_o,
                               bus.inst_data_i, {N{bus.inst_error_i}});
         end
         got_r = e_rr;
         got_f = e_fr;
         next_cycle();
         m_owner = n_owner; m_start = n_start; m_flushing = n_flushing; m_set = n_set;
      end
      drive_idle();
   endtask

   initial begin
      rst_i = 1'b1;
      drive_idle();
      test_reset();
      test_round_robin();
      test_lock();
      test_idle_no_req();
      test_flush();
      test_flush_during_lock();
      test_flush_mask();
      test_reset_mid_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
